// File: rtl/mux4_arbiter_pkg.sv
// rtl/mux4_arbiter_pkg.sv - shared types and constants for the four-way packet arbiter
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_arbiter_if.sv
// rtl/mux4_arbiter_if.sv - requester/sink stream bundle for the four-way packet arbiter
interface mux4_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       req_valid;
    logic [3:0]       req_last;
    logic [WIDTH-1:0] req_data0;
    logic [WIDTH-1:0] req_data1;
    logic [WIDTH-1:0] req_data2;
    logic [WIDTH-1:0] req_data3;
    logic [3:0]       req_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic [3:0]       grant;
    logic [1:0]       sel;
    logic             busy;

    modport slave (
        input  req_valid, req_last, req_data0, req_data1, req_data2, req_data3, out_ready,
        output req_ready, out_valid, out_data, out_last, grant, sel, busy
    );

    modport master (
        output req_valid, req_last, req_data0, req_data1, req_data2, req_data3, out_ready,
        input  req_ready, out_valid, out_data, out_last, grant, sel, busy
    );
endinterface

// File: rtl/mux4_arbiter_mux.sv
// rtl/mux4_arbiter_mux.sv - plain 4-input datapath multiplexer
module Multiplexer4 #(
    parameter int width = 8
) (
    input  logic [width-1:0] in0,
    input  logic [width-1:0] in1,
    input  logic [width-1:0] in2,
    input  logic [width-1:0] in3,
    input  logic [1:0]       sel,
    output logic [width-1:0] out
);
    always_comb begin
        unique case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end
endmodule

// File: rtl/mux4_arbiter_rr_pick4.sv
// rtl/mux4_arbiter_rr_pick4.sv - combinational round-robin picker over four requests
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       any
);
    // Search starts just after the last-served index and wraps back to it last.
    always_comb begin
        idx = ptr;
        any = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] cand;
            cand = ptr + 2'(k);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux4_arbiter.sv
// rtl/mux4_arbiter.sv - round-robin packet arbiter steering four streams onto one sink
module mux4_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mux4_arbiter_if.slave  bus
);
    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       grant_q, grant_d;

    logic [1:0]       pick_idx;
    logic             pick_any;
    logic [WIDTH:0]   mux_out;
    logic             busy_w;
    logic             out_valid_w;
    logic             out_last_w;
    logic             accept;

    rr_pick4 u_pick (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    Multiplexer4 #(
        .width (WIDTH + 1)
    ) u_mux (
        .in0 ({bus.req_last[0], bus.req_data0}),
        .in1 ({bus.req_last[1], bus.req_data1}),
        .in2 ({bus.req_last[2], bus.req_data2}),
        .in3 ({bus.req_last[3], bus.req_data3}),
        .sel (sel_q),
        .out (mux_out)
    );

    assign busy_w      = (state_q == BUSY);
    assign out_valid_w = busy_w && bus.req_valid[sel_q];
    assign out_last_w  = mux_out[WIDTH];
    assign accept      = out_valid_w && bus.out_ready;

    // Ownership only moves on the final accepted beat; new requests wait for IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_idx;
                    grant_d = onehot4(pick_idx);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept && out_last_w) begin
                    ptr_d   = sel_q;
                    grant_d = 4'b0000;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
        end
    end

    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = mux_out[WIDTH-1:0];
    assign bus.out_last  = out_last_w;
    assign bus.req_ready = (busy_w && bus.out_ready) ? onehot4(sel_q) : 4'b0000;
    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_w;

endmodule

// File: tb/tb_mux4_arbiter.sv
// tb/tb_mux4_arbiter.sv - directed vector bench for the four-way packet arbiter
module tb_mux4_arbiter;

    logic clk;
    logic rst_n;

    mux4_arbiter_if #(.WIDTH(32)) bus ();

    mux4_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] rv;
        logic [3:0] rl;
        logic       ordy;
        logic [7:0] beat;
        logic [3:0] eg;
        logic [1:0] es;
        logic       eb;
        logic       eov;
        logic       eol;
        logic [3:0] err;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [1:0] idx, input logic [7:0] beat);
        return ({30'd0, idx} + 32'd1) << 28 | {24'd0, beat};
    endfunction

    task automatic drive(input logic [3:0] rv, input logic [3:0] rl, input logic ordy,
                         input logic [7:0] beat);
        bus.req_valid = rv;
        bus.req_last  = rl;
        bus.out_ready = ordy;
        bus.req_data0 = exp_data(2'd0, beat);
        bus.req_data1 = exp_data(2'd1, beat);
        bus.req_data2 = exp_data(2'd2, beat);
        bus.req_data3 = exp_data(2'd3, beat);
    endtask

    task automatic add(input logic [3:0] rv, input logic [3:0] rl, input logic ordy,
                       input logic [7:0] beat, input logic [3:0] eg, input logic [1:0] es,
                       input logic eb, input logic eov, input logic eol, input logic [3:0] err);
        vec_t v;
        v.rv = rv; v.rl = rl; v.ordy = ordy; v.beat = beat;
        v.eg = eg; v.es = es; v.eb = eb; v.eov = eov; v.eol = eol; v.err = err;
        vq.push_back(v);
    endtask

    task automatic check_ctrl(input string name, input logic [3:0] eg, input logic [1:0] es,
                              input logic eb, input logic eov, input logic [3:0] err);
        chk(name, {52'd0, bus.grant, bus.sel, bus.busy, bus.out_valid, bus.req_ready},
                  {52'd0, eg, es, eb, eov, err});
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vq[i].rv, vq[i].rl, vq[i].ordy, vq[i].beat);
            #3;
            check_ctrl($sformatf("%s[%0d].ctrl", name, i), vq[i].eg, vq[i].es, vq[i].eb,
                       vq[i].eov, vq[i].err);
            if (vq[i].eov)
                chk($sformatf("%s[%0d].data", name, i), {31'd0, bus.out_last, bus.out_data},
                    {31'd0, vq[i].eol, exp_data(vq[i].es, vq[i].beat)});
        end
        vq.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(4'b0000, 4'b0000, 1'b0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        #3;
        check_ctrl("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000);

        // single requester, three beats
        add(4'h1, 4'h0, 1, 0, 4'h0, 0, 0, 0, 0, 4'h0);
        add(4'h1, 4'h0, 1, 1, 4'h1, 0, 1, 1, 0, 4'h1);
        add(4'h1, 4'h0, 1, 2, 4'h1, 0, 1, 1, 0, 4'h1);
        add(4'h1, 4'h1, 1, 3, 4'h1, 0, 1, 1, 1, 4'h1);
        add(4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 0, 0, 4'h0);
        run_table("single");

        // all four, single-beat packets: grants 0,1,2,3,0 two cycles apart
        do_reset();
        add(4'hF, 4'hF, 1, 0, 4'h0, 0, 0, 0, 0, 4'h0);
        for (int k = 0; k < 5; k++) begin
            logic [1:0] idx;
            idx = 2'(k);
            add(4'hF, 4'hF, 1, 0, 4'b0001 << idx, idx, 1, 1, 1, 4'b0001 << idx);
            if (k < 4) add(4'hF, 4'hF, 1, 0, 4'h0, idx, 0, 0, 0, 4'h0);
        end
        run_table("rr4");

        // fairness: 1 served first, then 1 and 3 alternate
        do_reset();
        add(4'h2, 4'h2, 1, 0, 4'h0, 0, 0, 0, 0, 4'h0);
        add(4'h2, 4'h2, 1, 0, 4'h2, 1, 1, 1, 1, 4'h2);
        add(4'hA, 4'hF, 1, 0, 4'h0, 1, 0, 0, 0, 4'h0);
        add(4'hA, 4'hF, 1, 0, 4'h8, 3, 1, 1, 1, 4'h8);
        add(4'hA, 4'hF, 1, 0, 4'h0, 3, 0, 0, 0, 4'h0);
        add(4'hA, 4'hF, 1, 0, 4'h2, 1, 1, 1, 1, 4'h2);
        add(4'hA, 4'hF, 1, 0, 4'h0, 1, 0, 0, 0, 4'h0);
        add(4'hA, 4'hF, 1, 0, 4'h8, 3, 1, 1, 1, 4'h8);
        add(4'hA, 4'hF, 1, 0, 4'h0, 3, 0, 0, 0, 4'h0);
        add(4'hA, 4'hF, 1, 0, 4'h2, 1, 1, 1, 1, 4'h2);
        run_table("fair");

        // backpressure: three stalled cycles on beat 1 of requester 2
        do_reset();
        add(4'h4, 4'h0, 0, 1, 4'h0, 0, 0, 0, 0, 4'h0);
        for (int k = 0; k < 3; k++)
            add(4'h4, 4'h0, 0, 1, 4'h4, 2, 1, 1, 0, 4'h0);
        add(4'h4, 4'h0, 1, 1, 4'h4, 2, 1, 1, 0, 4'h4);
        add(4'h4, 4'h4, 1, 2, 4'h4, 2, 1, 1, 1, 4'h4);
        add(4'h0, 4'h0, 1, 0, 4'h0, 2, 0, 0, 0, 4'h0);
        run_table("stall");

        // owner bubble while requester 2 waits
        do_reset();
        add(4'h5, 4'h0, 1, 1, 4'h0, 0, 0, 0, 0, 4'h0);
        add(4'h5, 4'h0, 1, 1, 4'h1, 0, 1, 1, 0, 4'h1);
        add(4'h4, 4'h0, 1, 1, 4'h1, 0, 1, 0, 0, 4'h1);
        add(4'h4, 4'h0, 1, 1, 4'h1, 0, 1, 0, 0, 4'h1);
        add(4'h5, 4'h1, 1, 2, 4'h1, 0, 1, 1, 1, 4'h1);
        add(4'h4, 4'h0, 1, 0, 4'h0, 0, 0, 0, 0, 4'h0);
        add(4'h4, 4'h4, 1, 0, 4'h4, 2, 1, 1, 1, 4'h4);
        run_table("bubble");

        // reset asserted during beat 2 of a 4-beat packet from requester 1
        do_reset();
        add(4'h2, 4'h0, 1, 0, 4'h0, 0, 0, 0, 0, 4'h0);
        add(4'h2, 4'h0, 1, 1, 4'h2, 1, 1, 1, 0, 4'h2);
        run_table("midrst");
        @(posedge clk);
        #1;
        drive(4'h2, 4'h0, 1'b1, 8'd2);
        #1;
        check_ctrl("midrst.beat2", 4'h2, 2'd1, 1'b1, 1'b1, 4'h2);
        rst_n = 1'b0;
        #1;
        check_ctrl("midrst.async", 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'h3, 4'h3, 1'b1, 8'd0);
        #2;
        check_ctrl("midrst.idle", 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);
        @(posedge clk);
        #1;
        check_ctrl("midrst.regrant", 4'h1, 2'd0, 1'b1, 1'b1, 4'h1);
        chk("midrst.data", {31'd0, bus.out_last, bus.out_data}, {31'd0, 1'b1, exp_data(2'd0, 8'd0)});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_arbiter.md
# mux4_arbiter

Round-robin arbiter that shares one downstream sink among four requesters by sequencing the select of a 4-input datapath multiplexer. Each requester offers a valid/ready stream of multi-beat packets delimited by `last`. A granted requester keeps the mux until its packet's final beat is accepted, so packets never interleave. The block sits between on-chip masters and a single shared consumer, such as a shared register-write port or memory request port.

## Interface
- `WIDTH`, 32, data width of each requester and of the output stream
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  4  per-requester beat valid (bit i = requester i)
- `req_last`  in  4  per-requester final-beat marker, qualified by `req_valid`
- `req_data0`..`req_data3`  in  WIDTH each  per-requester beat data
- `req_ready`  out  4  per-requester beat accepted strobe
- `out_valid`  out  1  beat valid toward sink
- `out_data`  out  WIDTH  beat data (muxed)
- `out_last`  out  1  final-beat marker (muxed)
- `out_ready`  in  1  sink accepts beat
- `grant`  out  4  one-hot owner of the mux; 0 when idle
- `sel`  out  2  registered mux select (index of owner)
- `busy`  out  1  high while a packet is owned

Decided: one clock `clk`; reset `rst_n`, asynchronous, active-low.

## Operation
- States: IDLE, BUSY.
- IDLE: if any `req_valid` bit is set, pick the winner by round-robin: search order `ptr+1, ptr+2, ptr+3, ptr` (mod 4), where `ptr` is the last-served index. Register `sel`=winner and `grant`=onehot(winner), then go to BUSY. If no request, stay in IDLE.
- BUSY:
  - `out_valid = req_valid[sel]`
  - `out_data`/`out_last` = requester `sel` fields
  - `req_ready[sel] = out_ready`; all other `req_ready` bits are 0.
  - Beat accepted when `out_valid && out_ready`.
  - On an accepted beat with `out_last=1`: go to IDLE, `ptr<=sel`, `grant<=0`.
- In IDLE: `out_valid=0`, `req_ready=0`. `out_data` shows requester `sel` and is a don't-care.
- Lock held: if the owner drops `req_valid` mid-packet, the grant stays and `out_valid=0`. There is no timeout.
- `req_valid` changes on non-owners never affect BUSY.
- Single-beat packet (`last=1` on the first beat) is legal.
- Reset values: state IDLE, `ptr`=3 (requester 0 has first priority), `sel`=0, `grant`=0, `busy`=0, `out_valid`=0, `req_ready`=0.
- Reset mid-packet: return immediately to the reset values. The partial packet is abandoned, and the requester must restart it.

## Timing
- Arbitration latency: a request sampled in IDLE at cycle N gives `grant`/`busy` high and a possible `out_valid` at N+1.
- Throughput in BUSY: one beat per cycle.
- `req_ready`, `out_valid`, `out_data` and `out_last` are combinational through the mux from registered `sel`.
- `out_ready` → `req_ready` is a combinational path with no register.
- Packet turnaround: final beat accepted at cycle M gives IDLE at M+1 (re-arbitration) and the next owner at M+2. There is exactly one bubble cycle between packets, including when the same requester wins again.
- Simultaneous final beat and new requests: new requests are only considered in the IDLE cycle. `ptr` is already updated there, so the just-served requester has lowest priority.

## Structure
- Package `arb_pkg`: state enum (IDLE, BUSY) and constant `NUM_REQ=4`.
- Sub-module `rr_pick4`: combinational round-robin picker with inputs `req[3:0]` and `ptr[1:0]`, and outputs `idx[1:0]` and `any`.
- The data/last path instantiates the existing `Multiplexer4`, with `width` set to `WIDTH+1` (`{last,data}`) and select driven by `sel`.

## Test plan
- Single request: `req_valid=0001`, 3-beat packet, `out_ready=1`.
  - `grant=0001` at N+1.
  - Beats A,B,C out on N+1..N+3.
  - `busy` low at N+4.
- All four request single-beat packets continuously from reset.
  - Grant order is 0,1,2,3,0.
  - Each grant is 2 cycles apart.
- Fairness: requesters 1 and 3 assert repeatedly after requester 1 was served.
  - Grant order is 3,1,3,1.
  - Requester 1 never wins twice in a row while 3 waits.
- Backpressure: owner sends 2 beats with `out_ready` low for 3 cycles on beat 1.
  - `out_data` stays stable.
  - `req_ready[owner]=0` during the stall.
  - No grant change.
- Owner bubble: owner drops `req_valid` for 2 cycles mid-packet while requester 2 requests.
  - `out_valid=0`, `grant` unchanged.
  - Requester 2 is granted only after the owner's final beat.
- Reset mid-packet: assert `rst_n=0` during beat 2 of 4.
  - All outputs go to reset values asynchronously.
  - After release, requester 0 wins first if requesting.
